// File: rtl/clk_rst_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : clk_rst_sequencer
// Description : Reset and clock-enable sequencer that sits behind the 160 MHz
//               system PLL. Waits for PLL lock to be stable, releases the
//               pixel/HDMI reset, then the system reset after a further delay,
//               and generates single-cycle pixel and CPU clock enables.
//               Loss of lock re-asserts both resets on the next edge.
// Ports       : clk           - 160 MHz clock from PLL clkout
//               reset_n       - asynchronous active-low reset
//               pll_lock      - PLL lock, asynchronous to clk
//               rst_pix_n     - active-low pixel/HDMI domain reset
//               rst_sys_n     - active-low system/core reset
//               ce_pix        - pixel clock enable, one clk wide
//               ce_cpu        - CPU clock enable, coincident with ce_pix
//               ready         - high while running
//               lock_lost_cnt - saturating count of lock losses after
//                               pixel reset release
// Options     : LOCK_LOSS_COUNT_EN - when defined, lock_lost_cnt is a real
//               counter; otherwise it is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_rst_sequencer #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1024,
    parameter int SYS_DELAY     = 256,
    parameter int PIX_DIV       = 5,
    parameter int CPU_DIV       = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_lock,
    output logic       rst_pix_n,
    output logic       rst_sys_n,
    output logic       ce_pix,
    output logic       ce_cpu,
    output logic       ready,
    output logic [7:0] lock_lost_cnt
);

    // One shared counter covers both the stability window and the
    // pixel-to-system delay, so it is sized for the larger of the two.
    localparam int c_CNT_MAX = (STABLE_CYCLES > SYS_DELAY) ? STABLE_CYCLES : SYS_DELAY;
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;
    localparam int c_PIX_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam int c_CPU_W   = (CPU_DIV > 1) ? $clog2(CPU_DIV) : 1;

    localparam logic [c_CNT_W-1:0] c_STABLE_LAST = c_CNT_W'(STABLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_SYS_LAST    = c_CNT_W'(SYS_DELAY - 1);
    localparam logic [c_PIX_W-1:0] c_PIX_LAST    = c_PIX_W'(PIX_DIV - 1);
    localparam logic [c_CPU_W-1:0] c_CPU_LAST    = c_CPU_W'(CPU_DIV - 1);

    localparam logic [1:0] c_ST_WAIT   = 2'd0;
    localparam logic [1:0] c_ST_STABLE = 2'd1;
    localparam logic [1:0] c_ST_PIX    = 2'd2;
    localparam logic [1:0] c_ST_RUN    = 2'd3;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_lock_s;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nx;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nx;

    logic               w_act;
    logic               w_act_nx;
    logic               w_run_nx;
    logic               w_pix_tick;

    logic [c_PIX_W-1:0] r_pix_cnt;
    logic [c_CPU_W-1:0] r_cpu_cnt;
    logic               r_rst_pix_n;
    logic               r_rst_sys_n;
    logic               r_ready;
    logic               r_ce_pix;
    logic               r_ce_cpu;

    // ------------------------------------------------------------------
    // Lock synchroniser
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pll_lock};
        end
    end

    assign w_lock_s = r_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Sequencer FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_ST_WAIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM: next state. A low lock_s is tested first so that it
    // always wins over a counter terminal condition in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            c_ST_WAIT: begin
                if (w_lock_s) begin
                    w_state_nx = c_ST_STABLE;
                end
            end
            c_ST_STABLE: begin
                if (!w_lock_s) begin
                    w_state_nx = c_ST_WAIT;
                end else if (r_cnt == c_STABLE_LAST) begin
                    w_state_nx = c_ST_PIX;
                end
            end
            c_ST_PIX: begin
                if (!w_lock_s) begin
                    w_state_nx = c_ST_WAIT;
                end else if (r_cnt == c_SYS_LAST) begin
                    w_state_nx = c_ST_RUN;
                end
            end
            default: begin
                if (!w_lock_s) begin
                    w_state_nx = c_ST_WAIT;
                end
            end
        endcase
    end

    // The counter only runs while staying in STABLE or PIX; every state
    // change clears it, so it starts from zero in each timed state and
    // never exceeds its terminal value.
    always_comb begin
        w_cnt_nx = '0;
        if ((w_state_nx == r_state) &&
            ((r_state == c_ST_STABLE) || (r_state == c_ST_PIX))) begin
            w_cnt_nx = r_cnt + 1'b1;
        end
    end

    assign w_act      = (r_state == c_ST_PIX) || (r_state == c_ST_RUN);
    assign w_act_nx   = (w_state_nx == c_ST_PIX) || (w_state_nx == c_ST_RUN);
    assign w_run_nx   = (w_state_nx == c_ST_RUN);
    assign w_pix_tick = (r_pix_cnt == c_PIX_LAST);

    // ------------------------------------------------------------------
    // Registered outputs, all derived from the next state so they change
    // on the same edge as the state itself.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rst_pix_n <= 1'b0;
            r_rst_sys_n <= 1'b0;
            r_ready     <= 1'b0;
        end else begin
            r_rst_pix_n <= w_act_nx;
            r_rst_sys_n <= w_run_nx;
            r_ready     <= w_run_nx;
        end
    end

    // Pixel divider counts only once PIX has actually been entered, which
    // puts the first ce_pix PIX_DIV edges after rst_pix_n rises. It keeps
    // running through PIX->RUN so the enable has no gap there.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pix_cnt <= '0;
            r_ce_pix  <= 1'b0;
        end else if (w_act && w_act_nx) begin
            r_pix_cnt <= w_pix_tick ? '0 : (r_pix_cnt + 1'b1);
            r_ce_pix  <= w_pix_tick;
        end else begin
            r_pix_cnt <= '0;
            r_ce_pix  <= 1'b0;
        end
    end

    // CPU divider advances on the same edge that raises ce_pix, so ce_cpu
    // can only ever be high together with ce_pix.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cpu_cnt <= '0;
            r_ce_cpu  <= 1'b0;
        end else if (!w_run_nx) begin
            r_cpu_cnt <= '0;
            r_ce_cpu  <= 1'b0;
        end else if (w_pix_tick) begin
            if (r_cpu_cnt == c_CPU_LAST) begin
                r_cpu_cnt <= '0;
                r_ce_cpu  <= 1'b1;
            end else begin
                r_cpu_cnt <= r_cpu_cnt + 1'b1;
                r_ce_cpu  <= 1'b0;
            end
        end else begin
            r_ce_cpu  <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Lock-loss counter: counts only losses seen after pixel release.
    // ------------------------------------------------------------------
`ifdef LOCK_LOSS_COUNT_EN
    logic       w_loss;
    logic [7:0] r_lost_cnt;

    assign w_loss = w_act && !w_lock_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lost_cnt <= 8'd0;
        end else if (w_loss && (r_lost_cnt != 8'hFF)) begin
            r_lost_cnt <= r_lost_cnt + 8'd1;
        end
    end

    assign lock_lost_cnt = r_lost_cnt;
`else
    assign lock_lost_cnt = 8'd0;
`endif

    assign rst_pix_n = r_rst_pix_n;
    assign rst_sys_n = r_rst_sys_n;
    assign ready     = r_ready;
    assign ce_pix    = r_ce_pix;
    assign ce_cpu    = r_ce_cpu;

endmodule
`default_nettype wire

// File: tb/tb_clk_rst_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_rst_sequencer
// Description : Directed self-checking bench for clk_rst_sequencer with
//               SYNC_STAGES=2, STABLE_CYCLES=16, SYS_DELAY=8, PIX_DIV=5,
//               CPU_DIV=4. Expected lock_lost_cnt follows LOCK_LOSS_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_rst_sequencer;

    logic       clk      = 1'b0;
    logic       reset_n  = 1'b0;
    logic       pll_lock = 1'b0;
    logic       rst_pix_n;
    logic       rst_sys_n;
    logic       ce_pix;
    logic       ce_cpu;
    logic       ready;
    logic [7:0] lock_lost_cnt;

    int checks   = 0;
    int errors   = 0;
    int lost_exp = 0;

    clk_rst_sequencer #(
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (16),
        .SYS_DELAY     (8),
        .PIX_DIV       (5),
        .CPU_DIV       (4)
    ) u_dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pll_lock      (pll_lock),
        .rst_pix_n     (rst_pix_n),
        .rst_sys_n     (rst_sys_n),
        .ce_pix        (ce_pix),
        .ce_cpu        (ce_cpu),
        .ready         (ready),
        .lock_lost_cnt (lock_lost_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".rst_pix_n"}, 0, {7'd0, rst_pix_n}, 8'd0);
        chk({tag, ".rst_sys_n"}, 0, {7'd0, rst_sys_n}, 8'd0);
        chk({tag, ".ce_pix"},    0, {7'd0, ce_pix},    8'd0);
        chk({tag, ".ce_cpu"},    0, {7'd0, ce_cpu},    8'd0);
        chk({tag, ".ready"},     0, {7'd0, ready},     8'd0);
        chk({tag, ".lost"},      0, lock_lost_cnt,     lost_exp[7:0]);
    endtask

    // Walks n edges from a clean start (FSM in WAIT, synchroniser clear,
    // pll_lock high) and checks every output against hand-derived timing:
    // rst_pix_n at edge pix_e, rst_sys_n/ready at sys_e, ce_pix every 5th
    // edge from pix_e+5, ce_cpu on every 4th ce_pix counted from sys_e.
    task automatic bringup(input string tag, input int pix_e, input int sys_e, input int n);
        int   npc;
        logic ep;
        logic ec;
        npc = 0;
        for (int k = 1; k <= n; k++) begin
            step();
            ep = (k >= pix_e + 5) && (((k - pix_e - 5) % 5) == 0);
            ec = 1'b0;
            if (ep && (k >= sys_e)) begin
                npc++;
                ec = ((npc % 4) == 0);
            end
            chk({tag, ".rst_pix_n"}, k, {7'd0, rst_pix_n}, {7'd0, (k >= pix_e)});
            chk({tag, ".rst_sys_n"}, k, {7'd0, rst_sys_n}, {7'd0, (k >= sys_e)});
            chk({tag, ".ready"},     k, {7'd0, ready},     {7'd0, (k >= sys_e)});
            chk({tag, ".ce_pix"},    k, {7'd0, ce_pix},    {7'd0, ep});
            chk({tag, ".ce_cpu"},    k, {7'd0, ce_cpu},    {7'd0, ec});
            chk({tag, ".cpu_wo_pix"}, k, {7'd0, (ce_cpu & ~ce_pix)}, 8'd0);
            chk({tag, ".lost"},      k, lock_lost_cnt,     lost_exp[7:0]);
        end
    endtask

    // Drops lock just after an edge: still released after two edges,
    // everything back to reset values on the third.
    task automatic lose(input string tag, input logic in_run);
        pll_lock = 1'b0;
        step();
        step();
        chk({tag, ".hold_pix"}, 2, {7'd0, rst_pix_n}, 8'd1);
        chk({tag, ".hold_sys"}, 2, {7'd0, rst_sys_n}, {7'd0, in_run});
        step();
`ifdef LOCK_LOSS_COUNT_EN
        if (lost_exp < 255) lost_exp++;
`endif
        chk_all_zero(tag);
    endtask

    initial begin
        // Reset held with lock present
        reset_n  = 1'b0;
        pll_lock = 1'b1;
        repeat (10) step();
        chk_all_zero("reset");

        // Power-up release
        @(negedge clk);
        reset_n = 1'b1;
        bringup("pwrup", 19, 27, 70);

        // Asynchronous reset between edges
        #3;
        reset_n = 1'b0;
        #1;
        chk_all_zero("async_rst");

        // Release again, glitch lock while STABLE cnt=10; full restart expected
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            step();
            chk("glitch.pre", k, {7'd0, rst_pix_n}, 8'd0);
        end
        pll_lock = 1'b0;
        step();
        pll_lock = 1'b1;
        bringup("glitch", 19, 27, 30);

        // Loss in RUN
        lose("run_loss", 1'b1);

        // Relock and repeat losses from PIX until the counter saturates
        for (int i = 0; i < 300; i++) begin
            pll_lock = 1'b1;
            repeat (19) step();
            lose("pix_loss", 1'b0);
        end
`ifdef LOCK_LOSS_COUNT_EN
        chk("saturate", 300, lock_lost_cnt, 8'd255);
`else
        chk("saturate", 300, lock_lost_cnt, 8'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
